onehot_decoder_hold: RTL and testbench
======================================

// Module: onehot_decoder_hold
// PURPOSE
//  Receive side of the one-hot/index encoder interface: takes a binary index plus valid and
//  drives the matching one-hot line, registered and held for HOLD_CYC cycles.
//  valid/ready handshake on the input. Per-line saturating hit counters for debug/coverage.
//  Sits downstream of the 4x2 encoder path; decodes its (valid, Y) back to line selects.
// PARAMETERS
//  IDX_W     2   index width; output width N = 2**IDX_W
//  HOLD_CYC  4   cycles each decoded line stays high; legal range >= 1
//  CNT_W     8   width of each per-line hit counter
// PORTS
//  clk       in   1          clock, all state on rising edge
//  rst_n     in   1          reset, asynchronous assert, active-low
//  valid_in  in   1          idx_in is valid this cycle
//  idx_in    in   IDX_W      binary index to decode
//  ready_out out  1          block can accept idx_in this cycle
//  clr_cnt   in   1          synchronous clear of all hit counters
//  y_out     out  N          one-hot decoded output, registered
//  y_valid   out  1          y_out carries a decoded value
//  hit_cnt   out  N*CNT_W    flattened counters; line k at [k*CNT_W +: CNT_W]
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, y_out=0, y_valid=0, hold_cnt=0, all hit_cnt=0.
//  ready_out is 1 during reset. Release is synchronous to clk.
//  Accept = valid_in & ready_out. Inputs while valid_in=0 are ignored, including idx_in.
//  FSM states IDLE, HOLD:
//   IDLE: ready_out=1. On accept: y_out<=1<<idx_in, y_valid<=1, hold_cnt<=HOLD_CYC-1, ->HOLD.
//   HOLD: ready_out=(hold_cnt==0). If hold_cnt!=0: decrement hold_cnt.
//     hold_cnt==0 with accept: reload y_out/hold_cnt from the new idx_in; stay HOLD.
//     There is no zero gap in y_out.
//     hold_cnt==0 without accept: y_out<=0, y_valid<=0, ->IDLE.
//  HOLD_CYC=1: hold_cnt loads 0, so back-to-back accepts every cycle are allowed.
//  Latency: y_out changes on the edge after accept. Each line is high exactly HOLD_CYC
//   cycles unless re-accepted. Re-accept of the same index extends the high time.
//  y_out is always zero or exactly one-hot. y_valid == |y_out.
//  hit_cnt[k] increments on every accept with idx_in==k. It saturates at 2**CNT_W-1, no wrap.
//  clr_cnt and accept in the same cycle: clear applies first, then the count.
//   The accepted line reads 1 and all other lines read 0.
//  rst_n asserted mid-HOLD: outputs zero immediately. The in-flight decode is dropped, not counted again.
//  hold_cnt width = $clog2(HOLD_CYC+1). Elaboration error if HOLD_CYC<1 or IDX_W<1.
// STRUCTURE
//  Shared package/include decoder_defs: state encodings ST_IDLE=1'b0 and ST_HOLD=1'b1.
//   It also holds function onehot(idx) returning N-bit 1<<idx.
//  Sub-module sat_counter #(CNT_W): inputs clk, rst_n, clr, inc; output cnt.
//   It saturates at max. Instantiated N times through a generate loop.
//  Top holds the FSM, hold_cnt, and the y_out/y_valid registers.
// TESTING (defaults IDX_W=2, HOLD_CYC=4, CNT_W=8)
//  1 Reset: rst_n=0 -> y_out=0000, y_valid=0, ready_out=1, hit_cnt=0. Release, idle 5 cyc -> unchanged.
//  2 Single decode: accept idx=2 at edge t -> y_out=0100 for t+1..t+4, 0000 at t+5.
//    ready_out is 0 for t+1..t+3 and 1 at t+4. hit_cnt[2]=1.
//  3 Back-to-back: accept idx=1, then hold valid_in=1 with idx=3.
//    The second accept lands on the 4th hold cycle; y_out goes 0010 -> 1000 with no 0000 cycle.
//  4 Ignore: valid_in=0, idx_in toggles 0..3 for 10 cycles -> y_out=0000, all hit_cnt unchanged.
//  5 Counters: 300 accepts of idx=0 -> hit_cnt[0]=255.
//    Then clr_cnt=1 with accept idx=0 in the same cycle -> hit_cnt[0]=1, others 0.
//  6 Reset mid-op: accept idx=3, drop rst_n 2 cycles later between edges.
//    y_out=0000 and y_valid=0 immediately; after release, accept idx=0 -> y_out=0001 next edge.

Source files
------------

// File: rtl/decoder_defs.sv
// Shared definitions for the one-hot decoder: FSM encodings and the index-to-line helper.
package decoder_defs;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Widest one-hot vector the helper can produce (8-bit index).
  localparam int unsigned ONEHOT_MAX_W = 256;

  function automatic logic [ONEHOT_MAX_W-1:0] onehot(input logic [7:0] idx);
    logic [ONEHOT_MAX_W-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes effect before the increment.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = inc ? CNT_W'(1) : '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/onehot_decoder_hold.sv
// Decodes an accepted binary index to a registered one-hot line held for HOLD_CYC cycles,
// with per-line saturating hit counters.
module onehot_decoder_hold
  import decoder_defs::*;
#(
  parameter  int unsigned IDX_W    = 2,
  parameter  int unsigned HOLD_CYC = 4,
  parameter  int unsigned CNT_W    = 8,
  localparam int unsigned N        = 2 ** IDX_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_in,
  input  logic [IDX_W-1:0]   idx_in,
  output logic               ready_out,
  input  logic               clr_cnt,
  output logic [N-1:0]       y_out,
  output logic               y_valid,
  output logic [N*CNT_W-1:0] hit_cnt
);

  localparam int unsigned HW = $clog2(HOLD_CYC + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYC - 1);

  if (HOLD_CYC < 1) begin : g_bad_hold
    $error("onehot_decoder_hold: HOLD_CYC must be >= 1");
  end
  if ((IDX_W < 1) || (IDX_W > 8)) begin : g_bad_idx
    $error("onehot_decoder_hold: IDX_W must be in 1..8");
  end

  logic [0:0]    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [N-1:0]  y_q, y_d;
  logic          yv_q, yv_d;
  logic          accept;
  logic [N-1:0]  line_sel;

  // IDLE always has hold_q==0, so one term covers both states.
  assign ready_out = (state_q == ST_IDLE) || (hold_q == '0);
  assign accept    = valid_in && ready_out;
  assign line_sel  = N'(onehot(8'(idx_in)));

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    y_d     = y_q;
    yv_d    = yv_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          y_d     = line_sel;
          yv_d    = 1'b1;
          hold_d  = HOLD_LOAD;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (hold_q != '0) begin
          hold_d = hold_q - HW'(1);
        end else if (accept) begin
          // Reload directly so the output never drops to zero between decodes.
          y_d    = line_sel;
          yv_d   = 1'b1;
          hold_d = HOLD_LOAD;
        end else begin
          y_d     = '0;
          yv_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        y_d     = '0;
        yv_d    = 1'b0;
        hold_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      y_q     <= '0;
      yv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
    end
  end

  assign y_out   = y_q;
  assign y_valid = yv_q;

  for (genvar k = 0; k < N; k++) begin : g_cnt
    sat_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clr_cnt),
      .inc  (accept && (idx_in == IDX_W'(k))),
      .cnt  (hit_cnt[k*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_onehot_decoder_hold.sv
// Directed bench for onehot_decoder_hold at default parameters.
module tb_onehot_decoder_hold;

  localparam int unsigned IDX_W    = 2;
  localparam int unsigned HOLD_CYC = 4;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned N        = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             valid_in;
  logic [IDX_W-1:0] idx_in;
  logic             ready_out;
  logic             clr_cnt;
  logic [N-1:0]     y_out;
  logic             y_valid;
  logic [N*CNT_W-1:0] hit_cnt;

  int checks   = 0;
  int failures = 0;
  logic [CNT_W-1:0] exp_cnt [N];

  always #5 clk = ~clk;

  onehot_decoder_hold #(
    .IDX_W   (IDX_W),
    .HOLD_CYC(HOLD_CYC),
    .CNT_W   (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_in (valid_in),
    .idx_in   (idx_in),
    .ready_out(ready_out),
    .clr_cnt  (clr_cnt),
    .y_out    (y_out),
    .y_valid  (y_valid),
    .hit_cnt  (hit_cnt)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    idx_in   = '0;
    clr_cnt  = 1'b0;
    for (int k = 0; k < N; k++) exp_cnt[k] = '0;
    #2;
    checks++; if (y_out !== 4'b0000) begin failures++; $display("FAIL reset_y: got %b expected 0000", y_out); end
    checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL reset_yvalid: got %b expected 0", y_valid); end
    checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", ready_out); end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (hit_cnt[k*CNT_W +: CNT_W] !== exp_cnt[k]) begin
        failures++; $display("FAIL reset_cnt%0d: got %0d expected %0d", k, hit_cnt[k*CNT_W +: CNT_W], exp_cnt[k]);
      end
    end
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    checks++; if (y_out !== 4'b0000) begin failures++; $display("FAIL idle_y: got %b expected 0000", y_out); end
    checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL idle_yvalid: got %b expected 0", y_valid); end
    checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL idle_ready: got %b expected 1", ready_out); end
  endtask

  task automatic test_single;
    logic [N-1:0] ey;
    logic         er;
    valid_in = 1'b1;
    idx_in   = 2'd2;
    tick();
    valid_in = 1'b0;
    idx_in   = 2'd1;
    for (int i = 1; i <= 5; i++) begin
      ey = (i <= 4) ? 4'b0100 : 4'b0000;
      er = (i >= 4);
      checks++; if (y_out !== ey) begin failures++; $display("FAIL single_y%0d: got %b expected %b", i, y_out, ey); end
      checks++; if (y_valid !== (i <= 4)) begin failures++; $display("FAIL single_yvalid%0d: got %b expected %b", i, y_valid, (i <= 4)); end
      checks++; if (ready_out !== er) begin failures++; $display("FAIL single_ready%0d: got %b expected %b", i, ready_out, er); end
      if (i < 5) tick();
    end
    exp_cnt[2] = 8'd1;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (hit_cnt[k*CNT_W +: CNT_W] !== exp_cnt[k]) begin
        failures++; $display("FAIL single_cnt%0d: got %0d expected %0d", k, hit_cnt[k*CNT_W +: CNT_W], exp_cnt[k]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [N-1:0] ey;
    valid_in = 1'b1;
    idx_in   = 2'd1;
    tick();
    idx_in = 2'd3;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (y_out !== 4'b0010) begin failures++; $display("FAIL b2b_first_y%0d: got %b expected 0010", i, y_out); end
      checks++; if (ready_out !== (i == 4)) begin failures++; $display("FAIL b2b_ready%0d: got %b expected %b", i, ready_out, (i == 4)); end
      tick();
    end
    for (int i = 5; i <= 9; i++) begin
      ey = (i <= 8) ? 4'b1000 : 4'b0000;
      checks++; if (y_out !== ey) begin failures++; $display("FAIL b2b_second_y%0d: got %b expected %b", i, y_out, ey); end
      if (i == 5) valid_in = 1'b0;
      if (i < 9) tick();
    end
    checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL b2b_end_yvalid: got %b expected 0", y_valid); end
    exp_cnt[1] = 8'd1;
    exp_cnt[3] = 8'd1;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (hit_cnt[k*CNT_W +: CNT_W] !== exp_cnt[k]) begin
        failures++; $display("FAIL b2b_cnt%0d: got %0d expected %0d", k, hit_cnt[k*CNT_W +: CNT_W], exp_cnt[k]);
      end
    end
  endtask

  task automatic test_ignore;
    valid_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      idx_in = 2'(i);
      tick();
      checks++; if (y_out !== 4'b0000) begin failures++; $display("FAIL ignore_y%0d: got %b expected 0000", i, y_out); end
      checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL ignore_yvalid%0d: got %b expected 0", i, y_valid); end
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (hit_cnt[k*CNT_W +: CNT_W] !== exp_cnt[k]) begin
        failures++; $display("FAIL ignore_cnt%0d: got %0d expected %0d", k, hit_cnt[k*CNT_W +: CNT_W], exp_cnt[k]);
      end
    end
  endtask

  task automatic test_counters;
    int acc;
    int cyc;
    acc = 0;
    cyc = 0;
    idx_in = 2'd0;
    while ((acc < 300) && (cyc < 4000)) begin
      valid_in = 1'b1;
      if (ready_out === 1'b1) acc++;
      tick();
      cyc++;
    end
    valid_in = 1'b0;
    checks++; if (acc != 300) begin failures++; $display("FAIL cnt_accept_timeout: got %0d accepts expected 300", acc); end
    exp_cnt[0] = 8'd255;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (hit_cnt[k*CNT_W +: CNT_W] !== exp_cnt[k]) begin
        failures++; $display("FAIL sat_cnt%0d: got %0d expected %0d", k, hit_cnt[k*CNT_W +: CNT_W], exp_cnt[k]);
      end
    end
    cyc = 0;
    while ((ready_out !== 1'b1) && (cyc < 20)) begin
      tick();
      cyc++;
    end
    checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL clr_wait_ready: got %b expected 1", ready_out); end
    clr_cnt  = 1'b1;
    valid_in = 1'b1;
    idx_in   = 2'd0;
    tick();
    clr_cnt  = 1'b0;
    valid_in = 1'b0;
    exp_cnt[0] = 8'd1;
    exp_cnt[1] = 8'd0;
    exp_cnt[2] = 8'd0;
    exp_cnt[3] = 8'd0;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (hit_cnt[k*CNT_W +: CNT_W] !== exp_cnt[k]) begin
        failures++; $display("FAIL clr_cnt%0d: got %0d expected %0d", k, hit_cnt[k*CNT_W +: CNT_W], exp_cnt[k]);
      end
    end
    repeat (HOLD_CYC + 1) tick();
    checks++; if (y_out !== 4'b0000) begin failures++; $display("FAIL clr_drain_y: got %b expected 0000", y_out); end
  endtask

  task automatic test_reset_mid;
    valid_in = 1'b1;
    idx_in   = 2'd3;
    tick();
    valid_in = 1'b0;
    checks++; if (y_out !== 4'b1000) begin failures++; $display("FAIL mid_pre_y: got %b expected 1000", y_out); end
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < N; k++) exp_cnt[k] = '0;
    checks++; if (y_out !== 4'b0000) begin failures++; $display("FAIL mid_rst_y: got %b expected 0000", y_out); end
    checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_yvalid: got %b expected 0", y_valid); end
    checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL mid_rst_ready: got %b expected 1", ready_out); end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (hit_cnt[k*CNT_W +: CNT_W] !== exp_cnt[k]) begin
        failures++; $display("FAIL mid_rst_cnt%0d: got %0d expected %0d", k, hit_cnt[k*CNT_W +: CNT_W], exp_cnt[k]);
      end
    end
    tick();
    rst_n = 1'b1;
    tick();
    valid_in = 1'b1;
    idx_in   = 2'd0;
    tick();
    valid_in = 1'b0;
    exp_cnt[0] = 8'd1;
    checks++; if (y_out !== 4'b0001) begin failures++; $display("FAIL mid_after_y: got %b expected 0001", y_out); end
    checks++; if (y_valid !== 1'b1) begin failures++; $display("FAIL mid_after_yvalid: got %b expected 1", y_valid); end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (hit_cnt[k*CNT_W +: CNT_W] !== exp_cnt[k]) begin
        failures++; $display("FAIL mid_after_cnt%0d: got %0d expected %0d", k, hit_cnt[k*CNT_W +: CNT_W], exp_cnt[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore();
    test_counters();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
